// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state codes, opcode/funct constants and ALU operation codes for multicycle_ctrl.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional macro CTRL_ILLEGAL_TRAP_EN adds the TRAP state code.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_ALU_WB   = 4'd7,
    ST_EXEC_I   = 4'd8,
    ST_IMM_WB   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11
`ifdef CTRL_ILLEGAL_TRAP_EN
    , ST_TRAP   = 4'd12
`endif
  } state_e;

  // Operation class selected by the FSM; alu_decode turns it into an ALU code
  typedef enum logic [1:0] {
    ALUC_ADD   = 2'd0,
    ALUC_SUB   = 2'd1,
    ALUC_FUNCT = 2'd2,
    ALUC_IMM   = 2'd3
  } alu_cls_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;
  localparam logic [3:0] ALU_NOR = 4'hC;

  // States that issue a memory request and wait for mem_ready
  function automatic logic is_access_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

  // Opcodes whose immediate is sign extended; logical immediates zero extend
  function automatic logic is_sext_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_ADDI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decode.sv
// alu_decode: maps the FSM's operation class plus opcode/funct to an ALU operation code.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module alu_decode
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4
) (
  input  alu_cls_e           i_cls,
  input  logic [5:0]         i_opcode,
  input  logic [5:0]         i_funct,
  output logic [ALUOP_W-1:0] o_alu_op
);

  logic [3:0] w_op;

  // Pick the ALU code: fixed add/sub, R-type funct field, or I-type opcode
  always_comb begin
    w_op = ALU_ADD;
    case (i_cls)
      ALUC_ADD: w_op = ALU_ADD;
      ALUC_SUB: w_op = ALU_SUB;
      ALUC_FUNCT: begin
        case (i_funct)
          FN_ADD, FN_ADDU: w_op = ALU_ADD;
          FN_SUB, FN_SUBU: w_op = ALU_SUB;
          FN_AND:          w_op = ALU_AND;
          FN_OR:           w_op = ALU_OR;
          FN_NOR:          w_op = ALU_NOR;
          FN_SLT:          w_op = ALU_SLT;
          default:         w_op = ALU_ADD;
        endcase
      end
      ALUC_IMM: begin
        case (i_opcode)
          OP_SLTI: w_op = ALU_SLT;
          OP_ANDI: w_op = ALU_AND;
          OP_ORI:  w_op = ALU_OR;
          default: w_op = ALU_ADD;
        endcase
      end
      default: w_op = ALU_ADD;
    endcase
  end

  assign o_alu_op = ALUOP_W'(w_op);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing a multicycle MIPS-subset datapath (optional macro CTRL_ILLEGAL_TRAP_EN).
// Latency: zero-wait memory gives R/I-type 4 cycles, LW 5, SW 4, branch/jump 3.
// Backpressure: memory stalls through mem_ready; after WAIT_MAX ready-low cycles the access aborts to FETCH and sets sticky bus_err.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int ALUOP_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_we,
  output logic               ir_we,
  output logic               iord,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               reg_we,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic               ext_sel,
  output logic [1:0]         pc_src,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               bus_err,
  output logic [3:0]         state
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic               illegal
`endif
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  state_e           r_state;
  state_e           w_next;
  logic             r_boot;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_bus_err;
  logic             w_access;
  logic             w_done;
  logic             w_timeout;
  alu_cls_e         w_alu_cls;

  // The cycle right after reset issues nothing, so no strobe can fire before the FSM settles
  assign w_access  = is_access_state(r_state) && !r_boot;
  assign w_done    = w_access && mem_ready;
  assign w_timeout = w_access && !mem_ready && (r_wait_cnt == CNT_W'(WAIT_MAX));

  // State register plus the one-cycle post-reset idle flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_boot  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_boot  <= 1'b0;
    end
  end

  // Wait counter: counts ready-low cycles of the current access, zero everywhere else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (w_access && !mem_ready && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_err <= 1'b0;
    end else if (w_timeout) begin
      r_bus_err <= 1'b1;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH: begin
        if (w_done) begin
          w_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:                          w_next = ST_EXEC_R;
          OP_LW, OP_SW:                      w_next = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:                    w_next = ST_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_next = ST_EXEC_I;
          OP_J:                              w_next = ST_JUMP;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:                           w_next = ST_TRAP;
`else
          default:                           w_next = ST_FETCH;
`endif
        endcase
      end
      ST_MEM_ADDR: w_next = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (w_timeout) begin
          w_next = ST_FETCH;
        end else if (w_done) begin
          w_next = ST_MEM_WB;
        end
      end
      ST_MEM_WR: begin
        if (w_timeout || w_done) begin
          w_next = ST_FETCH;
        end
      end
      ST_MEM_WB: w_next = ST_FETCH;
      ST_EXEC_R: w_next = ST_ALU_WB;
      ST_ALU_WB: w_next = ST_FETCH;
      ST_EXEC_I: w_next = ST_IMM_WB;
      ST_IMM_WB: w_next = ST_FETCH;
      ST_BRANCH: w_next = ST_FETCH;
      ST_JUMP:   w_next = ST_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ST_TRAP:   w_next = ST_TRAP;
`endif
      default:   w_next = ST_FETCH;
    endcase
  end

  // Output decode from state; strobes in FETCH/BRANCH also look at mem_ready/zero
  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    pc_src     = 2'd0;
    w_alu_cls  = ALUC_ADD;
    case (r_state)
      ST_FETCH: begin
        alu_src_b = 2'd1;
        mem_rd    = !r_boot;
        ir_we     = w_done;
        pc_we     = w_done;
      end
      ST_DECODE: alu_src_b = 2'd3;
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      ST_MEM_RD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
      end
      ST_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        w_alu_cls = ALUC_FUNCT;
      end
      ST_ALU_WB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        w_alu_cls = ALUC_IMM;
      end
      ST_IMM_WB: reg_we = 1'b1;
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = 2'd1;
        w_alu_cls = ALUC_SUB;
        pc_we     = (opcode == OP_BNE) ? !zero : zero;
      end
      ST_JUMP: begin
        pc_we  = 1'b1;
        pc_src = 2'd2;
      end
      default: ;
    endcase
  end

  assign ext_sel = is_sext_op(opcode);
  assign bus_err = r_bus_err;
  assign state   = r_state;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal = (r_state == ST_TRAP);
`endif

  alu_decode #(
    .ALUOP_W (ALUOP_W)
  ) u_alu_decode (
    .i_cls    (w_alu_cls),
    .i_opcode (opcode),
    .i_funct  (funct),
    .o_alu_op (alu_op)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and random instruction streams checked cycle by cycle
// against an instruction-level model of the controller (state sequence, strobes, muxes).
module tb_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int WM = 15;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEMADDR = 4'd2;
  localparam logic [3:0] S_MEMRD = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECR = 4'd6,  S_ALUWB  = 4'd7,  S_EXECI   = 4'd8;
  localparam logic [3:0] S_IMMWB = 4'd9,  S_BRANCH = 4'd10, S_JUMP    = 4'd11;
  localparam logic [3:0] S_TRAP  = 4'd12;

  // mux vector layout: {iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0], pc_src[1:0]}
  localparam logic [7:0] K_IORD = 8'h80, K_RD = 8'h40, K_MTR = 8'h20;
  localparam logic [7:0] K_ASA  = 8'h10, K_ASB = 8'h0C, K_PCS = 8'h03;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h20;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_we, ir_we, iord, mem_rd, mem_wr, reg_we, reg_dst, mem_to_reg, alu_src_a, ext_sel;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_op;
  logic       bus_err;
  logic [3:0] state;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.WAIT_MAX(WM), .ALUOP_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .ext_sel(ext_sel), .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .bus_err(bus_err), .state(state)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  typedef struct {
    logic [3:0] st;
    logic [4:0] strb;   // {ir_we, pc_we, reg_we, mem_rd, mem_wr}
    logic       rdy;
    logic [7:0] mux;
    logic [7:0] msk;
    logic       acare;
    logic [3:0] aop;
    logic       berr;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  logic m_berr = 1'b0;

  logic [5:0] ops [0:10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h02, 6'h3F};
  logic [5:0] fns [0:5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [7:0] mx(input logic io, input logic rd, input logic mtr, input logic asa,
                                    input logic [1:0] asb, input logic [1:0] pcs);
    return {io, rd, mtr, asa, asb, pcs};
  endfunction

  function automatic logic [3:0] fn_aop(input logic [5:0] fn);
    case (fn)
      6'h20, 6'h21: return ALU_ADD;
      6'h22, 6'h23: return ALU_SUB;
      6'h24:        return ALU_AND;
      6'h25:        return ALU_OR;
      6'h27:        return ALU_NOR;
      6'h2A:        return ALU_SLT;
      default:      return ALU_ADD;
    endcase
  endfunction

  function automatic logic [3:0] imm_aop(input logic [5:0] op);
    case (op)
      6'h0A:   return ALU_SLT;
      6'h0C:   return ALU_AND;
      6'h0D:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  // Mostly short stalls, occasionally exactly the limit or one past it
  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return WM + 1;
    if (r == 1) return WM;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic push(input logic [3:0] st, input logic [4:0] strb, input logic rdy,
                      input logic [7:0] mux, input logic [7:0] msk, input logic acare, input logic [3:0] aop);
    exp_t e;
    e.st = st; e.strb = strb; e.rdy = rdy; e.mux = mux; e.msk = msk;
    e.acare = acare; e.aop = aop; e.berr = m_berr;
    q.push_back(e);
  endtask

  // A memory access that waits d ready-low cycles; more than WM low cycles aborts it
  task automatic plan_wait(input logic [3:0] st, input logic [4:0] s_wait, input logic [4:0] s_done,
                           input logic [7:0] mux, input logic [7:0] msk, input int d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k <= WM; k++) begin
      if (k == d) begin
        push(st, s_done, 1'b1, mux, msk, 1'b0, 4'h0);
        ok = 1'b1;
        break;
      end
      push(st, s_wait, 1'b0, mux, msk, 1'b0, 4'h0);
    end
    if (!ok) m_berr = 1'b1;
  endtask

  task automatic plan_instr(input logic [5:0] op, input logic z, input logic [5:0] fn, input int df, input int dm);
    bit ok;
    plan_wait(S_FETCH, 5'b00010, 5'b11010, mx(0, 0, 0, 0, 2'd1, 2'd0), K_IORD | K_ASA | K_ASB | K_PCS, df, ok);
    if (!ok) return;
    push(S_DECODE, 5'b00000, 1'($urandom), mx(0, 0, 0, 0, 2'd3, 2'd0), K_ASA | K_ASB, 1'b0, 4'h0);
    case (op)
      6'h00: begin
        push(S_EXECR, 5'b00000, 1'($urandom), mx(0, 0, 0, 1, 2'd0, 2'd0), K_ASA | K_ASB, 1'b1, fn_aop(fn));
        push(S_ALUWB, 5'b00100, 1'($urandom), mx(0, 1, 0, 0, 2'd0, 2'd0), K_RD | K_MTR, 1'b0, 4'h0);
      end
      6'h23, 6'h2B: begin
        push(S_MEMADDR, 5'b00000, 1'($urandom), mx(0, 0, 0, 1, 2'd2, 2'd0), K_ASA | K_ASB, 1'b1, ALU_ADD);
        if (op == 6'h23) begin
          plan_wait(S_MEMRD, 5'b00010, 5'b00010, mx(1, 0, 0, 0, 2'd0, 2'd0), K_IORD, dm, ok);
          if (ok) push(S_MEMWB, 5'b00100, 1'($urandom), mx(0, 0, 1, 0, 2'd0, 2'd0), K_RD | K_MTR, 1'b0, 4'h0);
        end else begin
          plan_wait(S_MEMWR, 5'b00001, 5'b00001, mx(1, 0, 0, 0, 2'd0, 2'd0), K_IORD, dm, ok);
        end
      end
      6'h04, 6'h05:
        push(S_BRANCH, {1'b0, (op == 6'h04) ? z : !z, 3'b000}, 1'($urandom),
             mx(0, 0, 0, 1, 2'd0, 2'd1), K_ASA | K_ASB | K_PCS, 1'b1, ALU_SUB);
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin
        push(S_EXECI, 5'b00000, 1'($urandom), mx(0, 0, 0, 1, 2'd2, 2'd0), K_ASA | K_ASB, 1'b1, imm_aop(op));
        push(S_IMMWB, 5'b00100, 1'($urandom), mx(0, 0, 0, 0, 2'd0, 2'd0), K_RD, 1'b0, 4'h0);
      end
      6'h02: push(S_JUMP, 5'b01000, 1'($urandom), mx(0, 0, 0, 0, 2'd0, 2'd2), K_PCS, 1'b0, 4'h0);
      default: ;  // undefined opcode: DECODE is its last modelled cycle here
    endcase
  endtask

  task automatic check_cycle(input exp_t e, input logic [5:0] op);
    chk("state", 32'(state), 32'(e.st));
    chk("strobes", 32'({ir_we, pc_we, reg_we, mem_rd, mem_wr}), 32'(e.strb));
    chk("bus_err", 32'(bus_err), 32'(e.berr));
    if (e.msk != 8'h00)
      chk("mux", 32'({iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src} & e.msk), 32'(e.mux & e.msk));
    if (e.acare) chk("alu_op", 32'(alu_op), 32'(e.aop));
    if (op inside {6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0A}) chk("ext_sel", 32'(ext_sel), 32'd1);
    else if (op inside {6'h0C, 6'h0D}) chk("ext_sel", 32'(ext_sel), 32'd0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("illegal", 32'(illegal), 32'd0);
`endif
  endtask

  // Replay up to 'limit' planned cycles, driving mem_ready per cycle, then drop the rest
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int limit);
    exp_t e;
    bit   first;
    int   n;
    first = 1'b1;
    n = 0;
    while (q.size() > 0 && n < limit) begin
      e = q.pop_front();
      @(negedge clk);
      if (first) begin
        opcode = op; funct = fn; zero = z; first = 1'b0;
      end
      mem_ready = e.rdy;
      #1;
      check_cycle(e, op);
      n++;
    end
    q.delete();
  endtask

  task automatic exec(input logic [5:0] op, input logic [5:0] fn, input logic z, input int df, input int dm);
    plan_instr(op, z, fn, df, dm);
    run(op, fn, z, 1_000_000);
  endtask

  // Hold rst for n edges, then check the reset state and the quiet first cycle after it
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    repeat (n) @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 32'(S_FETCH));
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    rst = 1'b0;
    mem_ready = 1'b1;
    m_berr = 1'b0;
    #1;
    chk("boot_strobes", 32'({ir_we, pc_we, reg_we, mem_rd, mem_wr}), 32'd0);
    chk("boot_state", 32'(state), 32'(S_FETCH));
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("boot_illegal", 32'(illegal), 32'd0);
`endif
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    logic       saved_berr;
    int         n_ops;
`ifdef CTRL_ILLEGAL_TRAP_EN
    n_ops = 10;
`else
    n_ops = 11;
`endif

    do_reset(2);

    // R-type ADD, LW with a 3-cycle stall, SW zero-wait and stalled
    exec(6'h00, 6'h20, 1'b0, 0, 0);
    exec(6'h23, 6'h20, 1'b0, 0, 3);
    exec(6'h2B, 6'h20, 1'b0, 0, 0);
    exec(6'h2B, 6'h20, 1'b1, 1, 2);
    // Branches both ways, immediates, jump
    exec(6'h04, 6'h20, 1'b1, 0, 0);
    exec(6'h04, 6'h20, 1'b0, 0, 0);
    exec(6'h05, 6'h20, 1'b1, 0, 0);
    exec(6'h05, 6'h20, 1'b0, 0, 0);
    exec(6'h0C, 6'h20, 1'b0, 0, 0);
    exec(6'h08, 6'h20, 1'b0, 0, 0);
    exec(6'h0A, 6'h20, 1'b0, 2, 0);
    exec(6'h0D, 6'h20, 1'b0, 0, 0);
    exec(6'h02, 6'h20, 1'b0, 0, 0);
    // Ready exactly at the limit completes; one more low cycle aborts with sticky error
    exec(6'h00, 6'h22, 1'b0, WM, 0);
    exec(6'h00, 6'h24, 1'b0, WM + 1, 0);
    exec(6'h00, 6'h25, 1'b0, 0, 0);
    do_reset(1);
    exec(6'h23, 6'h20, 1'b0, 0, WM);
    exec(6'h23, 6'h20, 1'b0, 0, WM + 1);
    exec(6'h2B, 6'h20, 1'b0, 0, 0);
    do_reset(2);

    // Undefined opcode
`ifdef CTRL_ILLEGAL_TRAP_EN
    exec(6'h3F, 6'h20, 1'b0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      #1;
      chk("trap_state", 32'(state), 32'(S_TRAP));
      chk("trap_illegal", 32'(illegal), 32'd1);
      chk("trap_strobes", 32'({ir_we, pc_we, reg_we, mem_rd, mem_wr}), 32'd0);
    end
    do_reset(1);
`else
    exec(6'h3F, 6'h20, 1'b0, 0, 0);
`endif
    exec(6'h00, 6'h2A, 1'b0, 0, 0);

    // Reset while a store waits in MEM_WR: the write strobe must drop next cycle
    saved_berr = m_berr;
    plan_instr(6'h2B, 1'b0, 6'h20, 0, WM + 1);
    m_berr = saved_berr;
    run(6'h2B, 6'h20, 1'b0, 5);
    do_reset(1);

    // Random instruction stream
    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(0, n_ops - 1)];
      exec(op, fns[$urandom_range(0, 5)], 1'($urandom), pick_delay(), pick_delay());
      if (m_berr) do_reset(1 + int'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
